// File: rtl/edge_req_arbiter.sv
// Purpose: synchronise N async request lines, latch rising edges, grant them round-robin.
// Latency: input edge to gnt_vld is 4 clk (2-flop sync, edge detect, pending register, grant register).
// Backpressure: a grant is held until gnt_ack; new edges keep accumulating in pending meanwhile.
module edge_req_arbiter #(
  parameter int N   = 4,
  parameter int IDW = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   asynch_in,
  output logic           gnt_vld,
  output logic [IDW-1:0] gnt_id,
  input  logic           gnt_ack,
  output logic [N-1:0]   pending,
  output logic [N-1:0]   ovr,
  input  logic           clr_ovr
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t         state, state_nxt;
  logic [N-1:0]   sync1, sync2, det;
  logic [N-1:0]   edge_pls;
  logic [N-1:0]   clr_vec;
  logic [IDW-1:0] last_grant;
  logic [IDW-1:0] sel_idx;
  logic [IDW-1:0] cand;
  logic           sel_found;
  logic           ack_take;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
      det   <= '0;
    end else begin
      sync1 <= asynch_in;
      sync2 <= sync1;
      det   <= sync2;
    end
  end

  // Flops reset to 0, so a line held high across reset yields exactly one edge.
  assign edge_pls = sync2 & ~det;
  assign ack_take = (state == GRANT) && gnt_ack;

  always_comb begin
    clr_vec = '0;
    if (ack_take) clr_vec[gnt_id] = 1'b1;
  end

  // Search starts just after the last served channel and wraps.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = '0;
    for (int k = 1; k <= N; k++) begin
      cand = IDW'((int'(last_grant) + k) % N);
      if (!sel_found && pending[cand]) begin
        sel_found = 1'b1;
        sel_idx   = cand;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (sel_found) state_nxt = GRANT;
      GRANT:   if (gnt_ack)   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      gnt_vld    <= 1'b0;
      gnt_id     <= '0;
      last_grant <= IDW'(N - 1);
    end else begin
      state   <= state_nxt;
      gnt_vld <= (state_nxt == GRANT);
      if (state == IDLE && sel_found) gnt_id <= sel_idx;
      if (ack_take) last_grant <= gnt_id;
    end
  end

  // An edge landing on its own clear re-arms the request rather than counting as overrun.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= '0;
      ovr     <= '0;
    end else begin
      pending <= edge_pls | (pending & ~clr_vec);
      ovr     <= (clr_ovr ? '0 : ovr) | (edge_pls & pending & ~clr_vec);
    end
  end

endmodule

// File: tb/tb_edge_req_arbiter.sv
// Directed bench for edge_req_arbiter: per-cycle vector table plus reset and edge/clear corner sequences.
module tb_edge_req_arbiter;

  logic       clk;
  logic       rst_n;
  logic [3:0] asynch_in;
  logic       gnt_vld;
  logic [1:0] gnt_id;
  logic       gnt_ack;
  logic [3:0] pending;
  logic [3:0] ovr;
  logic       clr_ovr;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [3:0] a;
    logic       ack;
    logic       clr;
    logic       vld;
    logic [1:0] id;
    logic [3:0] pend;
    logic [3:0] ov;
  } vec_t;

  vec_t tv[$];

  edge_req_arbiter #(.N(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .asynch_in (asynch_in),
    .gnt_vld   (gnt_vld),
    .gnt_id    (gnt_id),
    .gnt_ack   (gnt_ack),
    .pending   (pending),
    .ovr       (ovr),
    .clr_ovr   (clr_ovr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  task automatic add(input logic [3:0] a, input logic ack, input logic clr,
                     input logic vld, input logic [1:0] id, input logic [3:0] pend,
                     input logic [3:0] ov);
    vec_t v;
    v.a = a; v.ack = ack; v.clr = clr; v.vld = vld; v.id = id; v.pend = pend; v.ov = ov;
    tv.push_back(v);
  endtask

  task automatic cyc(input logic [3:0] a, input logic ack, input logic clr);
    asynch_in = a;
    gnt_ack   = ack;
    clr_ovr   = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [3:0] a);
    asynch_in = a;
    gnt_ack   = 1'b0;
    clr_ovr   = 1'b0;
    rst_n     = 1'b0;
    #2;
    chk("rst_vld", gnt_vld, 0);
    chk("rst_id", gnt_id, 0);
    chk("rst_pend", pending, 0);
    chk("rst_ovr", ovr, 0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int grants;
    int hi_cnt;
    logic prev_vld;
    logic [1:0] seen_id;

    rst_n = 1'b1;
    asynch_in = '0;
    gnt_ack = 1'b0;
    clr_ovr = 1'b0;

    //   a     ack  clr  vld id   pend   ovr
    // Round-robin from reset: 0,1,2,3
    add(4'hF, 0, 0, 0, 0, 4'h0, 4'h0);
    add(4'hF, 0, 0, 0, 0, 4'h0, 4'h0);
    add(4'hF, 0, 0, 0, 0, 4'hF, 4'h0);
    add(4'hF, 0, 0, 1, 0, 4'hF, 4'h0);
    add(4'hF, 1, 0, 0, 0, 4'hE, 4'h0);
    add(4'hF, 0, 0, 1, 1, 4'hE, 4'h0);
    add(4'hF, 1, 0, 0, 1, 4'hC, 4'h0);
    add(4'hF, 0, 0, 1, 2, 4'hC, 4'h0);
    add(4'hF, 1, 0, 0, 2, 4'h8, 4'h0);
    add(4'hF, 0, 0, 1, 3, 4'h8, 4'h0);
    add(4'hF, 1, 0, 0, 3, 4'h0, 4'h0);
    add(4'hF, 1, 0, 0, 3, 4'h0, 4'h0);   // ack in IDLE ignored
    add(4'h0, 0, 0, 0, 3, 4'h0, 4'h0);
    add(4'h0, 0, 0, 0, 3, 4'h0, 4'h0);
    add(4'h0, 0, 0, 0, 3, 4'h0, 4'h0);
    // Serve channel 1, then 0 and 3 together -> 3 before 0
    add(4'h2, 0, 0, 0, 3, 4'h0, 4'h0);
    add(4'h2, 0, 0, 0, 3, 4'h0, 4'h0);
    add(4'h0, 0, 0, 0, 3, 4'h2, 4'h0);
    add(4'h0, 0, 0, 1, 1, 4'h2, 4'h0);
    add(4'h0, 1, 0, 0, 1, 4'h0, 4'h0);
    add(4'h9, 0, 0, 0, 1, 4'h0, 4'h0);
    add(4'h9, 0, 0, 0, 1, 4'h0, 4'h0);
    add(4'h0, 0, 0, 0, 1, 4'h9, 4'h0);
    add(4'h0, 0, 0, 1, 3, 4'h9, 4'h0);
    add(4'h0, 1, 0, 0, 3, 4'h1, 4'h0);
    add(4'h0, 0, 0, 1, 0, 4'h1, 4'h0);
    add(4'h0, 1, 0, 0, 0, 4'h0, 4'h0);
    add(4'h0, 0, 0, 0, 0, 4'h0, 4'h0);
    // Hold channel 1 granted, pulse channel 2 twice -> overrun, then clear it
    add(4'h2, 0, 0, 0, 0, 4'h0, 4'h0);
    add(4'h2, 0, 0, 0, 0, 4'h0, 4'h0);
    add(4'h0, 0, 0, 0, 0, 4'h2, 4'h0);
    add(4'h0, 0, 0, 1, 1, 4'h2, 4'h0);
    add(4'h4, 0, 0, 1, 1, 4'h2, 4'h0);
    add(4'h4, 0, 0, 1, 1, 4'h2, 4'h0);
    add(4'h0, 0, 0, 1, 1, 4'h6, 4'h0);
    add(4'h0, 0, 0, 1, 1, 4'h6, 4'h0);
    add(4'h0, 0, 0, 1, 1, 4'h6, 4'h0);
    add(4'h4, 0, 0, 1, 1, 4'h6, 4'h0);
    add(4'h4, 0, 0, 1, 1, 4'h6, 4'h0);
    add(4'h0, 0, 0, 1, 1, 4'h6, 4'h4);
    add(4'h0, 0, 1, 1, 1, 4'h6, 4'h0);
    add(4'h0, 0, 0, 1, 1, 4'h6, 4'h0);
    add(4'h0, 1, 0, 0, 1, 4'h4, 4'h0);
    add(4'h0, 0, 0, 1, 2, 4'h4, 4'h0);
    add(4'h0, 1, 0, 0, 2, 4'h0, 4'h0);

    do_reset(4'h0);
    for (int i = 0; i < tv.size(); i++) begin
      cyc(tv[i].a, tv[i].ack, tv[i].clr);
      chk($sformatf("tv%0d_vld", i), gnt_vld, tv[i].vld);
      chk($sformatf("tv%0d_id", i), gnt_id, tv[i].id);
      chk($sformatf("tv%0d_pend", i), pending, tv[i].pend);
      chk($sformatf("tv%0d_ovr", i), ovr, tv[i].ov);
    end

    // Edge of channel 0 coincides with the ack that clears it
    cyc(4'h1, 0, 0);
    cyc(4'h1, 0, 0);
    cyc(4'h0, 0, 0);
    chk("coin_pend0", pending, 4'h1);
    cyc(4'h0, 0, 0);
    chk("coin_vld0", gnt_vld, 1);
    chk("coin_id0", gnt_id, 0);
    cyc(4'h1, 0, 0);
    cyc(4'h1, 0, 0);
    cyc(4'h1, 1, 0);
    chk("coin_vld_ack", gnt_vld, 0);
    chk("coin_pend_kept", pending, 4'h1);
    chk("coin_ovr", ovr, 4'h0);
    cyc(4'h1, 0, 0);
    chk("coin_regrant", gnt_vld, 1);
    chk("coin_regrant_id", gnt_id, 0);
    cyc(4'h0, 1, 0);
    chk("coin_done_pend", pending, 4'h0);

    // Reset mid-grant with pending 1010
    do_reset(4'h0);
    cyc(4'hA, 0, 0);
    cyc(4'hA, 0, 0);
    cyc(4'h0, 0, 0);
    cyc(4'h0, 0, 0);
    chk("mid_vld", gnt_vld, 1);
    chk("mid_id", gnt_id, 1);
    chk("mid_pend", pending, 4'hA);
    #3;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_vld", gnt_vld, 0);
    chk("mid_rst_pend", pending, 4'h0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    hi_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      cyc(4'h0, 1, 0);
      if (gnt_vld) hi_cnt++;
    end
    chk("mid_no_grants", hi_cnt, 0);

    // Channel 3 held high through reset release: exactly one grant
    do_reset(4'h8);
    grants = 0;
    prev_vld = 1'b0;
    seen_id = '0;
    for (int i = 0; i < 12; i++) begin
      cyc(4'h8, 1, 0);
      if (gnt_vld && !prev_vld) begin
        grants++;
        seen_id = gnt_id;
      end
      prev_vld = gnt_vld;
    end
    chk("held_grants", grants, 1);
    chk("held_id", seen_id, 3);
    chk("held_pend", pending, 4'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
